// File: rtl/wb4_to_sram_pkg.sv
// Shared definitions for the WB4-to-async-SRAM slave: FSM state encodings,
// wait-counter width and the clog2 helper used across the codebase.
package wb4_to_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  // WAITCNT is limited to 0..15, so four bits cover the counter.
  localparam int WAIT_W = 4;

  // Ceiling log2 usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb4_to_sram.sv
// Pipelined Wishbone B4 slave driving an asynchronous SRAM, one transaction at
// a time, with WAITCNT extra access cycles. Optional feature macro
// WB4_TO_SRAM_ERR_EN adds wb4_err_o and rejects word indices that do not fit
// in the SRAM instead of wrapping them.
//
// Handshake: a request is accepted at a rising edge where wb4_cyc_i and
// wb4_stb_i are high and wb4_stall_o (registered) is low; wb4_ack_o (or
// wb4_err_o) is a one-cycle pulse that completes it. The master holds a
// stalled request until it is accepted.
module wb4_to_sram
  import wb4_to_sram_pkg::*;
#(
  parameter int ARCHBITSZ     = 16,
  parameter int SRAMADDRBITSZ = 16,
  parameter int WAITCNT       = 1
) (
  input  logic                     wb4_clk_i,
  input  logic                     wb4_rst_i,
  input  logic                     wb4_cyc_i,
  input  logic                     wb4_stb_i,
  input  logic                     wb4_we_i,
  input  logic [ARCHBITSZ-1:0]     wb4_addr_i,
  input  logic [ARCHBITSZ-1:0]     wb4_data_i,
  input  logic [ARCHBITSZ/8-1:0]   wb4_sel_i,
  output logic                     wb4_stall_o,
  output logic                     wb4_ack_o,
`ifdef WB4_TO_SRAM_ERR_EN
  output logic                     wb4_err_o,
`endif
  output logic [ARCHBITSZ-1:0]     wb4_data_o,
  output logic [SRAMADDRBITSZ-1:0] sram_addr_o,
  output logic [ARCHBITSZ-1:0]     sram_data_o,
  input  logic [ARCHBITSZ-1:0]     sram_data_i,
  output logic                     sram_data_oe_o,
  output logic                     sram_ce_n_o,
  output logic                     sram_oe_n_o,
  output logic                     sram_we_n_o,
  output logic [ARCHBITSZ/8-1:0]   sram_be_n_o
);

  localparam int SEL_W    = ARCHBITSZ / 8;
  localparam int ADDR_LSB = clog2(SEL_W);
  localparam int EXT_W    = ARCHBITSZ + SRAMADDRBITSZ;

  state_e                   state_q, state_d;
  logic [WAIT_W-1:0]        cnt_q, cnt_d;
  logic                     txn_we_q, txn_we_d;
  logic                     stall_q, stall_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic [ARCHBITSZ-1:0]     rdata_q, rdata_d;
  logic [SRAMADDRBITSZ-1:0] addr_q, addr_d;
  logic [ARCHBITSZ-1:0]     wdata_q, wdata_d;
  logic                     data_oe_q, data_oe_d;
  logic                     ce_n_q, ce_n_d;
  logic                     oe_n_q, oe_n_d;
  logic                     we_n_q, we_n_d;
  logic [SEL_W-1:0]         be_n_q, be_n_d;

  // Word index zero-extended so any SRAMADDRBITSZ/ARCHBITSZ mix slices cleanly;
  // bits above SRAMADDRBITSZ are the out-of-range part of the index.
  logic [EXT_W-1:0] idx_ext;
  assign idx_ext = {{SRAMADDRBITSZ{1'b0}}, wb4_addr_i} >> ADDR_LSB;

`ifdef WB4_TO_SRAM_ERR_EN
  logic idx_overflow;
  assign idx_overflow = |idx_ext[EXT_W-1:SRAMADDRBITSZ];
`else
  logic idx_hi_unused;
  assign idx_hi_unused = |idx_ext[EXT_W-1:SRAMADDRBITSZ];
  assign err_q         = 1'b0;
`endif

  // Next-state and next-output logic for the IDLE/ACCESS/ACK(/ERR) sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    txn_we_d  = txn_we_q;
    stall_d   = stall_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_oe_d = data_oe_q;
    ce_n_d    = ce_n_q;
    oe_n_d    = oe_n_q;
    we_n_d    = we_n_q;
    be_n_d    = be_n_q;
    case (state_q)
      ST_IDLE: begin
        stall_d = 1'b0;
        if (wb4_cyc_i && wb4_stb_i) begin
          stall_d = 1'b1;
          rdata_d = '0;
`ifdef WB4_TO_SRAM_ERR_EN
          if (idx_overflow) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else
`endif
          begin
            state_d   = ST_ACCESS;
            cnt_d     = WAIT_W'(WAITCNT);
            txn_we_d  = wb4_we_i;
            addr_d    = idx_ext[SRAMADDRBITSZ-1:0];
            wdata_d   = wb4_data_i;
            ce_n_d    = 1'b0;
            be_n_d    = ~wb4_sel_i;
            oe_n_d    = wb4_we_i;
            we_n_d    = ~wb4_we_i;
            data_oe_d = wb4_we_i;
          end
        end
      end
      ST_ACCESS: begin
        if (!wb4_cyc_i) begin
          // Master abandoned the cycle: release the SRAM, no ack.
          state_d   = ST_IDLE;
          stall_d   = 1'b0;
          ce_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          be_n_d    = '1;
          data_oe_d = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!txn_we_q) rdata_d = sram_data_i;
          // we_n rises while data and address are still driven (hold cycle).
          we_n_d  = 1'b1;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d   = ST_IDLE;
        stall_d   = 1'b0;
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        be_n_d    = '1;
        data_oe_d = 1'b0;
      end
      default: begin
        // ERR (or any illegal encoding) lasts one cycle and returns to IDLE.
        state_d   = ST_IDLE;
        stall_d   = 1'b0;
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        be_n_d    = '1;
        data_oe_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge wb4_clk_i) begin
    if (!wb4_rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      txn_we_q  <= 1'b0;
      stall_q   <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_oe_q <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      be_n_q    <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      txn_we_q  <= txn_we_d;
      stall_q   <= stall_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_oe_q <= data_oe_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      be_n_q    <= be_n_d;
    end
  end

`ifdef WB4_TO_SRAM_ERR_EN
  // Error pulse flop, present only with the range-check feature.
  always_ff @(posedge wb4_clk_i) begin
    if (!wb4_rst_i) err_q <= 1'b0;
    else            err_q <= err_d;
  end
  assign wb4_err_o = err_q;
`else
  logic err_unused;
  assign err_unused = err_d | err_q;
`endif

  assign wb4_stall_o    = stall_q;
  assign wb4_ack_o      = ack_q;
  assign wb4_data_o     = rdata_q;
  assign sram_addr_o    = addr_q;
  assign sram_data_o    = wdata_q;
  assign sram_data_oe_o = data_oe_q;
  assign sram_ce_n_o    = ce_n_q;
  assign sram_oe_n_o    = oe_n_q;
  assign sram_we_n_o    = we_n_q;
  assign sram_be_n_o    = be_n_q;

endmodule
